// File: rtl/boron_encrypt_core.sv
// boron_encrypt_core
//   Iterative BORON-80 block cipher, encrypt direction, one round per clock.
//   A 64-bit plaintext and an 80-bit key are loaded on an accepted start.
//   ROUNDS rounds then run, followed by final key whitening. The ciphertext is
//   then held until the consumer acknowledges it, or until a new start arrives.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      request; accepted when start_i && ready_o
//   plaintext_i  64-bit plaintext, sampled on accept
//   key_i        80-bit master key, sampled on accept
//   ready_o      high in IDLE and DONE
//   data_o       ciphertext; meaningful while valid_o is high
//   valid_o      high in DONE
//   ack_i        consumer acknowledge (DONE -> IDLE)
//   round_o      round counter (debug): rc in RUN, ROUNDS+1 in DONE, 0 in IDLE

// 4-bit BORON S-box, one per nibble lane.
module boron_sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);
  always_comb begin
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'h4;
      4'h2: y = 4'hB;
      4'h3: y = 4'h1;
      4'h4: y = 4'h7;
      4'h5: y = 4'h9;
      4'h6: y = 4'hC;
      4'h7: y = 4'hA;
      4'h8: y = 4'hD;
      4'h9: y = 4'h2;
      4'hA: y = 4'h0;
      4'hB: y = 4'hF;
      4'hC: y = 4'h8;
      4'hD: y = 4'h5;
      4'hE: y = 4'h3;
      default: y = 4'h6;
    endcase
  end
endmodule

module boron_encrypt_core #(
  parameter int ROUNDS = 25
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [63:0] plaintext_i,
  input  logic [79:0] key_i,
  output logic        ready_o,
  output logic [63:0] data_o,
  output logic        valid_o,
  input  logic        ack_i,
  output logic [4:0]  round_o
);

  localparam int         NUM_NIB = 16;
  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic        accept, last;
  logic [63:0] s_q, data_q;
  logic [79:0] k_q;
  logic [4:0]  rc_q;

  // ---------------- round datapath ----------------
  logic [63:0] s_ark, s_sub, s_new;
  logic [15:0] t0, t1, t2, t3, r0, r1, r2, r3;
  logic [79:0] k_rot, k_new;
  logic [3:0]  k_sb;

  assign s_ark = s_q ^ k_q[63:0];

  for (genvar i = 0; i < NUM_NIB; i++) begin : g_sb
    boron_sbox u_sb (.x(s_ark[4*i +: 4]), .y(s_sub[4*i +: 4]));
  end

  // Nibble shuffle {n3,n2,n1,n0} -> {n1,n0,n3,n2} is a byte swap per word.
  assign t0 = {s_sub[ 7: 0], s_sub[15: 8]};
  assign t1 = {s_sub[23:16], s_sub[31:24]};
  assign t2 = {s_sub[39:32], s_sub[47:40]};
  assign t3 = {s_sub[55:48], s_sub[63:56]};

  // Per-word left rotations by 1, 4, 7 and 9.
  assign r0 = {t0[14:0], t0[15]};
  assign r1 = {t1[11:0], t1[15:12]};
  assign r2 = {t2[ 8:0], t2[15:9]};
  assign r3 = {t3[ 6:0], t3[15:7]};

  assign s_new = {r3 ^ r2, r2, r1 ^ r0, r0};

  // Key schedule: rotate left 13, S-box the low nibble, fold rc into [63:59].
  assign k_rot = {k_q[66:0], k_q[79:67]};
  boron_sbox u_ksb (.x(k_rot[3:0]), .y(k_sb));
  assign k_new = {k_rot[79:64], k_rot[63:59] ^ rc_q, k_rot[58:4], k_sb};

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rc_q == LAST_RC) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready_o = 1'b1;
        valid_o = 1'b1;
        // A new start implicitly acknowledges the held result.
        if (start_i) begin
          accept  = 1'b1;
          state_d = RUN;
        end else if (ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- state / key / result registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q    <= '0;
      k_q    <= '0;
      rc_q   <= '0;
      data_q <= '0;
    end else if (accept) begin
      s_q  <= plaintext_i;
      k_q  <= key_i;
      rc_q <= 5'd1;
    end else if (state_q == RUN) begin
      s_q  <= s_new;
      k_q  <= k_new;
      rc_q <= rc_q + 5'd1;
      // Final whitening uses the key produced by the last round.
      if (last) data_q <= s_new ^ k_new[63:0];
    end else if (state_q == DONE && ack_i) begin
      rc_q <= '0;
    end
  end

  assign data_o  = data_q;
  assign round_o = rc_q;

endmodule
